dsp_mul_seq: RTL

Parametrised, sequential RISC-V M-extension multiplier for the sail-core execute stage, supporting MUL, MULH, MULHSU and MULHU. It computes the full 2·XLEN product by iterating PART×PART unsigned partial products through one shared multiplier (one DSP slice), accumulating over multiple cycles. A valid/ready handshake on both sides lets the pipeline stall on it. It generalises the fixed two-slice 32-bit MULH datapath to any width, any signedness mode, and low/high result select.

---
 rtl/dsp_mul_pkg.sv | 5 +
 rtl/dsp_mul_pp.sv | 10 +
 rtl/dsp_mul_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/dsp_mul_pkg.sv
// dsp_mul_pkg: op and state encodings shared by the multiplier and the decoder
package dsp_mul_pkg;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, ACCUM = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
endpackage

// File: rtl/dsp_mul_pp.sv
// dsp_mul_pp: PART x PART unsigned combinational multiplier, maps to one DSP slice
module dsp_mul_pp #(
    parameter int PART = 16
) (
    input  logic [PART-1:0]   a,
    input  logic [PART-1:0]   b,
    output logic [2*PART-1:0] p
);
    assign p = (2*PART)'(a) * (2*PART)'(b);
endmodule

// File: rtl/dsp_mul_seq.sv
// dsp_mul_seq: sequential RISC-V M-extension multiplier iterating partial products through one DSP
module dsp_mul_seq
    import dsp_mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PART = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    localparam int NSEG = XLEN / PART;
    localparam int NPP  = NSEG * NSEG;
    localparam int IW   = NPP > 1 ? $clog2(NPP) : 1;
    localparam int W2   = 2 * XLEN;
    state_t            state, state_n;
    op_t               op, op_in;
    logic [XLEN-1:0]   mag_a, mag_b, ma, mb;
    logic              neg, sa, sb;
    logic [W2-1:0]     acc, term;
    logic [IW-1:0]     idx;
    logic [PART-1:0]   pa, pb;
    logic [2*PART-1:0] pp;
    int                seg_i, seg_j;
    dsp_mul_pp #(.PART(PART)) u_pp (.a(pa), .b(pb), .p(pp));
    always_comb begin
        op_in = op_t'(in_op);
        sa    = (op_in == OP_MULH || op_in == OP_MULHSU) && in_a[XLEN-1];
        sb    = op_in == OP_MULH && in_b[XLEN-1];
        ma    = sa ? -in_a : in_a;
        mb    = sb ? -in_b : in_b;
        seg_i = int'(idx) / NSEG;
        seg_j = int'(idx) % NSEG;
        pa    = mag_a[seg_i*PART +: PART];
        pb    = mag_b[seg_j*PART +: PART];
        term  = W2'(pp) << ((seg_i + seg_j) * PART);
    end
    always_comb begin
        state_n = flush            ? IDLE :
                  state == IDLE    ? (in_valid ? ACCUM : IDLE) :
                  state == ACCUM   ? (idx == IW'(NPP-1) ? FIX : ACCUM) :
                  state == FIX     ? DONE :
                                     (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_ff @(posedge clk)
        if (reset) begin
            op    <= OP_MUL;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            idx   <= '0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                op    <= op_in;
                mag_a <= ma;
                mag_b <= mb;
                neg   <= sa ^ sb;
                acc   <= '0;
                idx   <= '0;
            end else if (state == ACCUM) begin
                acc <= acc + term;
                idx <= idx + IW'(1);
            end else if (state == FIX && neg) begin
                acc <= -acc;
            end
        end
    assign in_ready   = state == IDLE;
    assign out_valid  = state == DONE;
    assign out_result = op == OP_MUL ? acc[XLEN-1:0] : acc[W2-1:XLEN];
endmodule
